// File: rtl/vga_plot_arbiter.sv
// Round-robin arbiter for the vga_adapter single-pixel write port.
// It also contains a raster-order full-screen clear sequencer.
module vga_plot_arbiter #(
  parameter int unsigned N_REQ            = 2,
  parameter int unsigned BITS_PER_CHANNEL = 1,
  parameter int unsigned WIDTH            = 336,
  parameter int unsigned HEIGHT           = 210,
  parameter int unsigned WIDTH2           = $clog2(WIDTH),
  parameter int unsigned HEIGHT2          = $clog2(HEIGHT)
) (
  input  logic                                          clk,
  input  logic                                          reset,
  input  logic [N_REQ-1:0]                              i_req_valid,
  output logic [N_REQ-1:0]                              o_req_ready,
  input  logic [N_REQ-1:0][WIDTH2-1:0]                  i_req_x,
  input  logic [N_REQ-1:0][HEIGHT2-1:0]                 i_req_y,
  input  logic [N_REQ-1:0][2:0][BITS_PER_CHANNEL-1:0]   i_req_color,
  input  logic                                          i_clear_start,
  input  logic [2:0][BITS_PER_CHANNEL-1:0]              i_clear_color,
  output logic                                          o_clear_busy,
  output logic                                          o_clear_done,
  output logic [WIDTH2-1:0]                             o_x,
  output logic [HEIGHT2-1:0]                            o_y,
  output logic [2:0][BITS_PER_CHANNEL-1:0]              o_color,
  output logic                                          o_plot
);

  localparam int unsigned PtrW = $clog2(N_REQ);
  localparam logic [WIDTH2-1:0]  XLast = WIDTH2'(WIDTH - 1);
  localparam logic [HEIGHT2-1:0] YLast = HEIGHT2'(HEIGHT - 1);

  typedef logic [2:0][BITS_PER_CHANNEL-1:0] color_t;
  typedef enum logic [0:0] {StArb, StClear} state_e;

  state_e              state_q;
  logic [PtrW-1:0]     ptr_q;
  logic [WIDTH2-1:0]   clr_x_q, clr_x_d, pix_x;
  logic [HEIGHT2-1:0]  clr_y_q, clr_y_d, pix_y;
  color_t              clr_color_q;
  logic                pix_last;

  logic                grant_any;
  logic [PtrW-1:0]     grant_idx, cand, ptr_next;
  logic                on_screen;

  // Search starts at the pointer so the last-served requester goes to the back.
  always_comb begin
    o_req_ready = '0;
    grant_any   = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    if (state_q == StArb && !i_clear_start) begin
      for (int unsigned i = 0; i < N_REQ; i++) begin
        cand = PtrW'((32'(ptr_q) + i) % N_REQ);
        if (!grant_any && i_req_valid[cand]) begin
          grant_any = 1'b1;
          grant_idx = cand;
        end
      end
      if (grant_any) o_req_ready[grant_idx] = 1'b1;
    end
  end

  always_comb begin
    ptr_next  = PtrW'((32'(grant_idx) + 1) % N_REQ);
    on_screen = (32'(i_req_x[grant_idx]) < WIDTH) && (32'(i_req_y[grant_idx]) < HEIGHT);
  end

  // Pixel emitted this cycle: (0,0) on the start cycle, else the sweep counters.
  always_comb begin
    pix_x    = (state_q == StClear) ? clr_x_q : '0;
    pix_y    = (state_q == StClear) ? clr_y_q : '0;
    pix_last = (pix_x == XLast) && (pix_y == YLast);
    clr_x_d  = pix_x + 1'b1;
    clr_y_d  = pix_y;
    if (pix_last) begin
      clr_x_d = '0;
      clr_y_d = '0;
    end else if (pix_x == XLast) begin
      clr_x_d = '0;
      clr_y_d = pix_y + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= StArb;
      ptr_q        <= '0;
      clr_x_q      <= '0;
      clr_y_q      <= '0;
      clr_color_q  <= '0;
      o_clear_busy <= 1'b0;
      o_clear_done <= 1'b0;
      o_x          <= '0;
      o_y          <= '0;
      o_color      <= '0;
      o_plot       <= 1'b0;
    end else begin
      o_clear_done <= 1'b0;
      unique case (state_q)
        StArb: begin
          o_clear_busy <= 1'b0;
          o_plot       <= 1'b0;
          if (i_clear_start) begin
            clr_color_q  <= i_clear_color;
            clr_x_q      <= clr_x_d;
            clr_y_q      <= clr_y_d;
            o_x          <= pix_x;
            o_y          <= pix_y;
            o_color      <= i_clear_color;
            o_plot       <= 1'b1;
            o_clear_busy <= 1'b1;
            if (pix_last) o_clear_done <= 1'b1;
            else          state_q      <= StClear;
          end else if (grant_any) begin
            o_x     <= i_req_x[grant_idx];
            o_y     <= i_req_y[grant_idx];
            o_color <= i_req_color[grant_idx];
            o_plot  <= on_screen;
            ptr_q   <= ptr_next;
          end
        end
        StClear: begin
          clr_x_q      <= clr_x_d;
          clr_y_q      <= clr_y_d;
          o_x          <= pix_x;
          o_y          <= pix_y;
          o_color      <= clr_color_q;
          o_plot       <= 1'b1;
          o_clear_busy <= 1'b1;
          if (pix_last) begin
            o_clear_done <= 1'b1;
            state_q      <= StArb;
          end
        end
        default: state_q <= StArb;
      endcase
    end
  end

endmodule

// File: tb/tb_vga_plot_arbiter.sv
// Directed bench for vga_plot_arbiter on a 4x3 screen with two requesters.
// x is 3 bits wide so that x=WIDTH can be presented as an off-screen pixel.
module tb_vga_plot_arbiter;

  logic             clk = 1'b0;
  logic             reset;
  logic [1:0]       req_valid, req_ready;
  logic [1:0][2:0]  req_x;
  logic [1:0][1:0]  req_y;
  logic [1:0][2:0][0:0] req_color;
  logic             clear_start;
  logic [2:0][0:0]  clear_color;
  logic             clear_busy, clear_done;
  logic [2:0]       x;
  logic [1:0]       y;
  logic [2:0][0:0]  color;
  logic             plot;

  int checks = 0;
  int errors = 0;

  vga_plot_arbiter #(
    .N_REQ(2), .BITS_PER_CHANNEL(1), .WIDTH(4), .HEIGHT(3), .WIDTH2(3), .HEIGHT2(2)
  ) dut (
    .clk(clk), .reset(reset),
    .i_req_valid(req_valid), .o_req_ready(req_ready),
    .i_req_x(req_x), .i_req_y(req_y), .i_req_color(req_color),
    .i_clear_start(clear_start), .i_clear_color(clear_color),
    .o_clear_busy(clear_busy), .o_clear_done(clear_done),
    .o_x(x), .o_y(y), .o_color(color), .o_plot(plot)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    logic [12:0] got;
    reset = 1'b1; req_valid = '0; req_x = '0; req_y = '0; req_color = '0;
    clear_start = 1'b0; clear_color = '0;
    #12;
    got = {req_ready, clear_busy, clear_done, x, y, color, plot};
    checks++;
    if (got !== 13'd0) begin errors++; $display("FAIL reset_state got %h exp 0", got); end
    tick; reset = 1'b0;
    tick; tick;
    got = {req_ready, clear_busy, clear_done, x, y, color, plot};
    checks++;
    if (got !== 13'd0) begin errors++; $display("FAIL idle_state got %h exp 0", got); end
    clear_color = 3'b111; clear_start = 1'b1;
    tick; clear_start = 1'b0;
    tick; tick;
    checks++;
    if ({clear_busy, plot} !== 2'b11)
      begin errors++; $display("FAIL clear_running got %b exp 11", {clear_busy, plot}); end
    reset = 1'b1; #1;
    got = {req_ready, clear_busy, clear_done, x, y, color, plot};
    checks++;
    if (got !== 13'd0) begin errors++; $display("FAIL reset_async got %h exp 0", got); end
    tick;
    got = {req_ready, clear_busy, clear_done, x, y, color, plot};
    checks++;
    if (got !== 13'd0) begin errors++; $display("FAIL reset_mid_clear got %h exp 0", got); end
    reset = 1'b0;
    tick;
    checks++;
    if ({clear_busy, plot} !== 2'b00)
      begin errors++; $display("FAIL no_resume got %b exp 00", {clear_busy, plot}); end
    req_valid = 2'b11; #1;
    checks++;
    if (req_ready !== 2'b01) begin errors++; $display("FAIL ptr_reset got %b exp 01", req_ready); end
    req_valid = 2'b00;
  endtask

  task automatic test_single;
    req_valid = 2'b01; req_x[0] = 3'd2; req_y[0] = 2'd1; req_color[0] = 3'b101;
    #1;
    checks++;
    if (req_ready !== 2'b01) begin errors++; $display("FAIL single_ready got %b exp 01", req_ready); end
    tick; req_valid = 2'b00; #1;
    checks++;
    if ({plot, x, y, color} !== {1'b1, 3'd2, 2'd1, 3'b101})
      begin errors++; $display("FAIL single_plot got %h exp %h", {plot, x, y, color},
                               {1'b1, 3'd2, 2'd1, 3'b101}); end
    checks++;
    if (req_ready !== 2'b00) begin errors++; $display("FAIL idle_ready got %b exp 00", req_ready); end
    tick;
    checks++;
    if ({plot, x, y, color} !== {1'b0, 3'd2, 2'd1, 3'b101})
      begin errors++; $display("FAIL hold_outputs got %h exp %h", {plot, x, y, color},
                               {1'b0, 3'd2, 2'd1, 3'b101}); end
  endtask

  // Pointer is 1 on entry; every grant here goes to req1, leaving the pointer at 0.
  task automatic test_offscreen;
    req_valid = 2'b10; req_x[1] = 3'd4; req_y[1] = 2'd0; req_color[1] = 3'b111; #1;
    checks++;
    if (req_ready !== 2'b10) begin errors++; $display("FAIL offx_ready got %b exp 10", req_ready); end
    tick; req_valid = 2'b00; #1;
    checks++;
    if (plot !== 1'b0) begin errors++; $display("FAIL offx_dropped got %b exp 0", plot); end
    req_valid = 2'b10; req_x[1] = 3'd0; req_y[1] = 2'd3; #1;
    checks++;
    if (req_ready !== 2'b10) begin errors++; $display("FAIL offy_ready got %b exp 10", req_ready); end
    tick; req_valid = 2'b00; #1;
    checks++;
    if (plot !== 1'b0) begin errors++; $display("FAIL offy_dropped got %b exp 0", plot); end
    req_valid = 2'b10; req_x[1] = 3'd3; req_y[1] = 2'd2; req_color[1] = 3'b110; #1;
    tick; req_valid = 2'b00; #1;
    checks++;
    if ({plot, x, y} !== {1'b1, 3'd3, 2'd2})
      begin errors++; $display("FAIL corner_plot got %h exp %h", {plot, x, y}, {1'b1, 3'd3, 2'd2}); end
  endtask

  task automatic test_back_to_back;
    req_x[0] = 3'd1; req_y[0] = 2'd0; req_color[0] = 3'b001;
    req_x[1] = 3'd3; req_y[1] = 2'd1; req_color[1] = 3'b110;
    req_valid = 2'b11;
    for (int c = 0; c < 6; c++) begin
      #1;
      checks++;
      if (req_ready !== ((c % 2 == 0) ? 2'b01 : 2'b10))
        begin errors++; $display("FAIL b2b_grant%0d got %b exp %b", c, req_ready,
                                 (c % 2 == 0) ? 2'b01 : 2'b10); end
      if (c > 0) begin
        checks++;
        if ({plot, x, y} !== ((c % 2 == 1) ? {1'b1, 3'd1, 2'd0} : {1'b1, 3'd3, 2'd1}))
          begin errors++; $display("FAIL b2b_plot%0d got %h", c - 1, {plot, x, y}); end
      end
      tick;
    end
    req_valid = 2'b00; #1;
    checks++;
    if ({plot, x, y, color} !== {1'b1, 3'd3, 2'd1, 3'b110})
      begin errors++; $display("FAIL b2b_plot5 got %h exp %h", {plot, x, y, color},
                               {1'b1, 3'd3, 2'd1, 3'b110}); end
    tick;
    checks++;
    if (plot !== 1'b0) begin errors++; $display("FAIL b2b_after got %b exp 0", plot); end
  endtask

  task automatic test_clear;
    logic [12:0] got, exp;
    req_valid = 2'b01; req_x[0] = 3'd3; req_y[0] = 2'd2; req_color[0] = 3'b111;
    clear_color = 3'b010; clear_start = 1'b1; #1;
    checks++;
    if (req_ready !== 2'b00) begin errors++; $display("FAIL clear_start_ready got %b exp 00", req_ready); end
    tick; clear_start = 1'b0; clear_color = 3'b000;
    for (int k = 1; k <= 12; k++) begin
      #1;
      got = {plot, clear_busy, clear_done, req_ready, x, y, color};
      exp = {1'b1, 1'b1, (k == 12), (k == 12) ? 2'b01 : 2'b00,
             3'((k - 1) % 4), 2'((k - 1) / 4), 3'b010};
      checks++;
      if (got !== exp) begin errors++; $display("FAIL clear_px%0d got %h exp %h", k, got, exp); end
      tick;
    end
    req_valid = 2'b00; #1;
    got = {plot, clear_busy, clear_done, req_ready, x, y, color};
    exp = {1'b1, 1'b0, 1'b0, 2'b00, 3'd3, 2'd2, 3'b111};
    checks++;
    if (got !== exp) begin errors++; $display("FAIL clear_then_req got %h exp %h", got, exp); end
    tick;
  endtask

  task automatic test_restart;
    int ndone = 0, nplot = 0, done_at = 0;
    clear_color = 3'b100; clear_start = 1'b1;
    tick;
    for (int k = 1; k <= 14; k++) begin
      clear_start = (k == 5);
      if (k == 5) clear_color = 3'b011;
      #1;
      if (clear_done) begin ndone++; done_at = k; end
      if (plot) nplot++;
      if (k == 6) begin
        checks++;
        if ({x, y, color} !== {3'd1, 2'd1, 3'b100})
          begin errors++; $display("FAIL restart_px5 got %h exp %h", {x, y, color},
                                   {3'd1, 2'd1, 3'b100}); end
      end
      tick;
    end
    clear_start = 1'b0;
    checks++;
    if (ndone !== 1) begin errors++; $display("FAIL restart_done_count got %0d exp 1", ndone); end
    checks++;
    if (done_at !== 12) begin errors++; $display("FAIL restart_done_cycle got %0d exp 12", done_at); end
    checks++;
    if (nplot !== 12) begin errors++; $display("FAIL restart_plot_count got %0d exp 12", nplot); end
    checks++;
    if (clear_busy !== 1'b0) begin errors++; $display("FAIL restart_busy got %b exp 0", clear_busy); end
  endtask

  initial begin
    test_reset;
    test_single;
    test_offscreen;
    test_back_to_back;
    test_clear;
    test_restart;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
